// File: rtl/icache_pkg.sv
// Shared geometry, FSM state type and word-select helper for the instruction cache.
package icache_pkg;

  localparam int TAG_BITS    = 25;
  localparam int INDEX_BITS  = 3;
  localparam int OFFSET_BITS = 4;
  localparam int BLOCK_BITS  = 128;
  localparam int LINES       = 1 << INDEX_BITS;
  localparam int BLKADR_BITS = TAG_BITS + INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MEM_READ  = 2'd1,
    FILL_DONE = 2'd2
  } state_e;

  function automatic logic [31:0] select_word(input logic [BLOCK_BITS-1:0] blk,
                                              input logic [1:0]            word);
    return blk[32*word +: 32];
  endfunction

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage: one write port, combinational read of one line.
module icache_line_array
  import icache_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [INDEX_BITS-1:0] rd_index_i,
  output logic                  rd_valid_o,
  output logic [TAG_BITS-1:0]   rd_tag_o,
  output logic [BLOCK_BITS-1:0] rd_data_o,
  input  logic                  we_i,
  input  logic [INDEX_BITS-1:0] wr_index_i,
  input  logic [TAG_BITS-1:0]   wr_tag_i,
  input  logic [BLOCK_BITS-1:0] wr_data_i
);

  logic [LINES-1:0]      valid_q;
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [BLOCK_BITS-1:0] data_q [LINES];

  // Valid bits clear asynchronously so an aborted fill never leaves a live line.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  // Tag and data need no reset; they are qualified by the valid bit.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[wr_index_i]  <= wr_tag_i;
      data_q[wr_index_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_data_o  = data_q[rd_index_i];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: hit compare, word select and refill FSM.
module instruction_cache
  import icache_pkg::*;
(
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   read,
  input  logic [31:0]            address,
  output logic [31:0]            instruction,
  output logic                   busywait,
  output logic                   mem_read,
  output logic [BLKADR_BITS-1:0] mem_address,
  input  logic [BLOCK_BITS-1:0]  mem_readdata,
  input  logic                   mem_busywait
);

  state_e                 state_q, state_d;
  logic [BLKADR_BITS-1:0] miss_addr_q, miss_addr_d;

  logic [INDEX_BITS-1:0]  addr_index;
  logic [TAG_BITS-1:0]    addr_tag;
  logic                   line_valid;
  logic [TAG_BITS-1:0]    line_tag;
  logic [BLOCK_BITS-1:0]  line_data;
  logic                   hit;
  logic                   fill_we;
  logic                   unused_byte_bits;

  assign addr_index       = address[OFFSET_BITS +: INDEX_BITS];
  assign addr_tag         = address[31 -: TAG_BITS];
  // Byte offset within a word is dropped silently.
  assign unused_byte_bits = ^address[1:0];

  icache_line_array u_lines (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .rd_index_i (addr_index),
    .rd_valid_o (line_valid),
    .rd_tag_o   (line_tag),
    .rd_data_o  (line_data),
    .we_i       (fill_we),
    .wr_index_i (miss_addr_q[INDEX_BITS-1:0]),
    .wr_tag_i   (miss_addr_q[BLKADR_BITS-1 -: TAG_BITS]),
    .wr_data_i  (mem_readdata)
  );

  assign hit         = read & line_valid & (line_tag == addr_tag);
  assign instruction = line_valid ? select_word(line_data, address[3:2]) : 32'h0;
  assign mem_address = miss_addr_q;

  // Next-state and output decode; the refill always targets the latched miss address.
  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    fill_we     = 1'b0;
    busywait    = 1'b0;
    mem_read    = 1'b0;
    case (state_q)
      IDLE: begin
        busywait = read & ~hit;
        if (read && !hit) begin
          miss_addr_d = address[31:OFFSET_BITS];
          state_d     = MEM_READ;
        end
      end
      MEM_READ: begin
        mem_read = 1'b1;
        busywait = 1'b1;
        if (!mem_busywait) begin
          fill_we = 1'b1;
          state_d = FILL_DONE;
        end
      end
      FILL_DONE: begin
        busywait = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and miss-address registers; reset drops mem_read immediately.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
    end
  end

endmodule

// File: tb/tb_instruction_cache.sv
// Self-checking bench: directed table, reset-abort sequence and randomized accesses.
module tb_instruction_cache;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         read;
  logic [31:0]  address;
  logic [31:0]  instruction;
  logic         busywait;
  logic         mem_read;
  logic [27:0]  mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  int checks = 0;
  int failures = 0;
  int mem_lat = 0;
  int mem_cnt = 0;

  instruction_cache dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .read         (read),
    .address      (address),
    .instruction  (instruction),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
  );

  always #5 CLK = ~CLK;

  // Main memory: each block's content is a fixed function of its block address.
  function automatic logic [127:0] memblk(input logic [27:0] a);
    if (a == 28'h0) return 128'h00000013_00000093_00100113_00000513;
    return {4'h3, a, 4'h2, a, 4'h1, a, 4'h0, a};
  endfunction

  function automatic logic [31:0] word_of(input logic [127:0] b, input logic [1:0] w);
    return b[32*w +: 32];
  endfunction

  // Memory holds mem_busywait for mem_lat edges after it first sees mem_read.
  always @(posedge CLK) begin
    if (mem_read) mem_cnt <= mem_cnt + 1;
    else          mem_cnt <= 0;
  end
  assign mem_busywait = mem_read && (mem_cnt < mem_lat);
  assign mem_readdata = memblk(mem_address);

  // Reference model: cache contents as plain arrays.
  bit           mv [8];
  logic [24:0]  mt [8];
  logic [127:0] md [8];

  task automatic model_clear();
    for (int i = 0; i < 8; i++) mv[i] = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_access(input logic rd, input logic [31:0] a, input int lat,
                            input bit drop, input bit exp_miss,
                            input logic [31:0] exp_instr, input logic [27:0] exp_maddr);
    int n;
    int nmr;
    logic [2:0] idx;
    mem_lat = lat;
    read    = rd;
    address = a;
    #1;
    chk("busywait_initial", {31'd0, busywait}, {31'd0, exp_miss});
    if (!exp_miss) begin
      if (rd) chk("hit_instruction", instruction, exp_instr);
      chk("hit_mem_read", {31'd0, mem_read}, 32'd0);
      @(posedge CLK); #1;
      chk("hit_busywait_next", {31'd0, busywait}, 32'd0);
      chk("hit_mem_read_next", {31'd0, mem_read}, 32'd0);
      return;
    end
    n   = 0;
    nmr = 0;
    do begin
      @(posedge CLK); #1;
      n++;
      if (mem_read) begin
        nmr++;
        if (nmr == 1) chk("miss_mem_address", {4'd0, mem_address}, {4'd0, exp_maddr});
      end
      if (drop && n == 2) read = 1'b0;
    end while (busywait && n < 60);
    chk("miss_busy_edges", n, lat + 3);
    chk("miss_mem_read_cycles", nmr, lat + 1);
    if (drop) begin
      chk("drop_busywait_idle", {31'd0, busywait}, 32'd0);
      read = 1'b1;
      #1;
    end
    chk("fill_busywait_low", {31'd0, busywait}, 32'd0);
    chk("fill_instruction", instruction, exp_instr);
    idx     = a[6:4];
    mv[idx] = 1'b1;
    mt[idx] = a[31:7];
    md[idx] = memblk(a[31:4]);
  endtask

  typedef struct {
    logic        rd;
    logic [31:0] a;
    int          lat;
    bit          drop;
    bit          miss;
    logic [31:0] instr;
    logic [27:0] maddr;
  } vec_t;

  vec_t tbl [9];
  logic [24:0] tag_pool [4];

  initial begin
    tbl[0] = '{1'b1, 32'h0000_0000, 3, 1'b0, 1'b1, 32'h0000_0513, 28'h000_0000};
    tbl[1] = '{1'b1, 32'h0000_0004, 0, 1'b0, 1'b0, 32'h0010_0113, 28'h0};
    tbl[2] = '{1'b1, 32'h0000_0008, 0, 1'b0, 1'b0, 32'h0000_0093, 28'h0};
    tbl[3] = '{1'b1, 32'h0000_000C, 0, 1'b0, 1'b0, 32'h0000_0013, 28'h0};
    tbl[4] = '{1'b1, 32'h0000_0007, 0, 1'b0, 1'b0, 32'h0010_0113, 28'h0};
    tbl[5] = '{1'b1, 32'h0000_0080, 2, 1'b1, 1'b1, 32'h0000_0008, 28'h000_0008};
    tbl[6] = '{1'b1, 32'h0000_0000, 1, 1'b0, 1'b1, 32'h0000_0513, 28'h000_0000};
    tbl[7] = '{1'b1, 32'hFFFF_FFFC, 4, 1'b0, 1'b1, 32'h3FFF_FFFF, 28'hFFF_FFFF};
    tbl[8] = '{1'b0, 32'h1234_5678, 0, 1'b0, 1'b0, 32'h0, 28'h0};
    tag_pool[0] = 25'h0;
    tag_pool[1] = 25'h1;
    tag_pool[2] = 25'h2;
    tag_pool[3] = 25'h1FF_FFFF;

    RESET   = 1'b1;
    read    = 1'b0;
    address = 32'h0;
    model_clear();
    #2;
    chk("reset_mem_read", {31'd0, mem_read}, 32'd0);
    chk("reset_busywait", {31'd0, busywait}, 32'd0);
    chk("reset_instruction", instruction, 32'h0);
    chk("reset_mem_address", {4'd0, mem_address}, 32'd0);
    #10;
    RESET = 1'b0;

    // read low: never stalls, never requests memory
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK); #1;
      address = $urandom;
      #1;
      chk("idle_read0_busywait", {31'd0, busywait}, 32'd0);
      chk("idle_read0_mem_read", {31'd0, mem_read}, 32'd0);
    end

    for (int i = 0; i < 9; i++) begin
      run_access(tbl[i].rd, tbl[i].a, tbl[i].lat, tbl[i].drop,
                 tbl[i].miss, tbl[i].instr, tbl[i].maddr);
    end

    // reset in the middle of a refill
    @(posedge CLK); #1;
    mem_lat = 10;
    read    = 1'b1;
    address = 32'h10;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("abort_mem_read_before", {31'd0, mem_read}, 32'd1);
    RESET = 1'b1;
    #1;
    chk("abort_mem_read_async", {31'd0, mem_read}, 32'd0);
    read = 1'b0;
    #1;
    RESET = 1'b0;
    model_clear();
    @(posedge CLK); #1;
    run_access(1'b1, 32'h10, 2, 1'b0, 1'b1, 32'h0000_0001, 28'h1);

    // randomized accesses against the array model
    for (int i = 0; i < 60; i++) begin
      logic        rd;
      logic [31:0] a;
      logic [2:0]  idx;
      bit          hit;
      bit          miss;
      logic [31:0] exp;
      rd   = ($urandom_range(0, 7) != 0);
      a    = {tag_pool[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
      idx  = a[6:4];
      hit  = rd && mv[idx] && (mt[idx] == a[31:7]);
      miss = rd && !hit;
      exp  = hit ? word_of(md[idx], a[3:2]) : word_of(memblk(a[31:4]), a[3:2]);
      run_access(rd, a, $urandom_range(0, 4), miss && ($urandom_range(0, 3) == 0),
                 miss, exp, a[31:4]);
      @(posedge CLK); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
